// File: rtl/mem_access_pkg.sv
// Shared encodings for the load/store initiator: access sizes, error codes,
// FSM states and the default ROM/RAM boundary.
package mem_access_pkg;

  typedef enum logic [1:0] {
    SIZE_B = 2'b00,
    SIZE_H = 2'b01,
    SIZE_W = 2'b10,
    SIZE_X = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ERR_NONE  = 2'b00,
    ERR_ALIGN = 2'b01,
    ERR_ROM   = 2'b10
  } err_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    READ  = 2'b01,
    WRITE = 2'b10,
    RESP  = 2'b11
  } state_e;

  localparam logic [31:0] ROM_LIMIT_DEFAULT = 32'h1000_0000;

  // Illegal size counts as misaligned so both share one error code.
  function automatic logic misaligned(input size_e size, input logic [1:0] offset);
    case (size)
      SIZE_B:  misaligned = 1'b0;
      SIZE_H:  misaligned = offset[0];
      SIZE_W:  misaligned = (offset != 2'b00);
      default: misaligned = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_lane_align.sv
// Combinational lane steering: extracts and extends a load lane, and merges a
// store lane into an existing memory word.
module lane_align
  import mem_access_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] word_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [1:0]            offset_i,
  input  size_e                 size_i,
  input  logic                  unsigned_i,
  output logic [DATA_WIDTH-1:0] load_o,
  output logic [DATA_WIDTH-1:0] merge_o
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  assign byte_lane = word_i[{offset_i, 3'b000} +: 8];
  assign half_lane = word_i[{offset_i[1], 4'b0000} +: 16];

  // NOTE: every output gets a default first so no path through the case infers a latch.
  always_comb begin
    load_o  = word_i;
    merge_o = word_i;
    case (size_i)
      SIZE_B: begin
        load_o = unsigned_i ? DATA_WIDTH'(byte_lane)
                            : {{(DATA_WIDTH-8){byte_lane[7]}}, byte_lane};
        merge_o[{offset_i, 3'b000} +: 8] = wdata_i[7:0];
      end
      SIZE_H: begin
        load_o = unsigned_i ? DATA_WIDTH'(half_lane)
                            : {{(DATA_WIDTH-16){half_lane[15]}}, half_lane};
        merge_o[{offset_i[1], 4'b0000} +: 16] = wdata_i[15:0];
      end
      default: merge_o = wdata_i;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store initiator: one request at a time, word-aligned memory accesses,
// read-modify-write for sub-word stores, alignment and ROM-write rejection.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] ROM_LIMIT  = DATA_WIDTH'(ROM_LIMIT_DEFAULT)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_write_i,
  input  logic [1:0]            req_size_i,
  input  logic                  req_unsigned_i,
  input  logic [DATA_WIDTH-1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  output logic                  resp_valid_o,
  output logic [DATA_WIDTH-1:0] resp_rdata_o,
  output logic [1:0]            resp_err_o,
  output logic [DATA_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  output logic                  mem_we_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] addr_q, addr_d;
  size_e                 size_q, size_d;
  logic                  write_q, write_d;
  logic                  unsigned_q, unsigned_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  err_e                  err_q, err_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;

  err_e                  acc_err;
  logic [DATA_WIDTH-1:0] load_val;
  logic [DATA_WIDTH-1:0] merge_val;

  lane_align #(.DATA_WIDTH(DATA_WIDTH)) u_lane_align (
    .word_i    (mem_rdata_i),
    .wdata_i   (wdata_q),
    .offset_i  (addr_q[1:0]),
    .size_i    (size_q),
    .unsigned_i(unsigned_q),
    .load_o    (load_val),
    .merge_o   (merge_val)
  );

  // Alignment outranks the ROM check.
  always_comb begin
    acc_err = ERR_NONE;
    if (misaligned(size_e'(req_size_i), req_addr_i[1:0])) begin
      acc_err = ERR_ALIGN;
    end else if (req_write_i && (req_addr_i < ROM_LIMIT)) begin
      acc_err = ERR_ROM;
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    size_d      = size_q;
    write_d     = write_q;
    unsigned_d  = unsigned_q;
    wdata_d     = wdata_q;
    err_d       = err_q;
    rdata_d     = rdata_q;
    mem_wdata_d = mem_wdata_q;
    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          addr_d     = req_addr_i;
          size_d     = size_e'(req_size_i);
          write_d    = req_write_i;
          unsigned_d = req_unsigned_i;
          wdata_d    = req_wdata_i;
          err_d      = acc_err;
          rdata_d    = '0;
          if (acc_err != ERR_NONE) begin
            state_d = RESP;
          end else if (req_write_i && (size_e'(req_size_i) == SIZE_W)) begin
            mem_wdata_d = req_wdata_i;
            state_d     = WRITE;
          end else begin
            state_d = READ;
          end
        end
      end
      READ: begin
        if (write_q) begin
          mem_wdata_d = merge_val;
          state_d     = WRITE;
        end else begin
          rdata_d = load_val;
          state_d = RESP;
        end
      end
      WRITE:   state_d = RESP;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      size_q      <= SIZE_B;
      write_q     <= 1'b0;
      unsigned_q  <= 1'b0;
      wdata_q     <= '0;
      err_q       <= ERR_NONE;
      rdata_q     <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      size_q      <= size_d;
      write_q     <= write_d;
      unsigned_q  <= unsigned_d;
      wdata_q     <= wdata_d;
      err_q       <= err_d;
      rdata_q     <= rdata_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  // Outputs decode straight from registered state, so reset clears them at once.
  assign req_ready_o  = (state_q == IDLE);
  assign resp_valid_o = (state_q == RESP);
  assign resp_rdata_o = (state_q == RESP) ? rdata_q : '0;
  assign resp_err_o   = (state_q == RESP) ? err_q : ERR_NONE;
  assign mem_we_o     = (state_q == WRITE);
  assign mem_addr_o   = {addr_q[DATA_WIDTH-1:2], 2'b00};
  assign mem_wdata_o  = mem_wdata_q;

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store initiator that sits between the core's data-path and the ROM/RAM memory system. It accepts one byte, halfword or word request at a time and converts it into word-aligned accesses. Sub-word stores become a read-modify-write sequence; loads are sign- or zero-extended. Misaligned accesses and stores into the ROM region are rejected with an error response and never reach memory.

## Interface
Parameters:
- DATA_WIDTH, 32, data and address width.
- ROM_LIMIT, 32'h1000_0000, first RAM byte address; addresses below it are ROM.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid_i  in  1  request present.
- req_ready_o  out  1  unit can accept a request.
- req_write_i  in  1  1 = store, 0 = load.
- req_size_i  in  2  00 byte, 01 half, 10 word, 11 illegal.
- req_unsigned_i  in  1  zero-extend loads when 1.
- req_addr_i  in  DATA_WIDTH  byte address.
- req_wdata_i  in  DATA_WIDTH  store data, right-aligned.
- resp_valid_o  out  1  one-cycle response strobe.
- resp_rdata_o  out  DATA_WIDTH  load result; 0 for stores and errors.
- resp_err_o  out  2  00 ok, 01 misaligned/illegal size, 10 ROM write.
- mem_addr_o  out  DATA_WIDTH  word address, {addr[31:2],2'b00}.
- mem_wdata_o  out  DATA_WIDTH  word write data.
- mem_we_o  out  1  memory write enable.
- mem_rdata_i  in  DATA_WIDTH  memory read data, combinational from mem_addr_o.

## Operation
- States: IDLE, READ, WRITE, RESP.
- IDLE:
  - req_ready_o=1.
  - A handshake (req_valid_i & req_ready_o) latches addr, size, write, unsigned and wdata.
- Error check at acceptance:
  - err 01: size 11, half with addr[0]=1, or word with addr[1:0]≠0.
  - err 10: write with addr < ROM_LIMIT (unsigned compare).
  - Misalignment has priority over the ROM error.
  - Any error → go to RESP directly; no memory access.
- Next state on acceptance:
  - load → READ.
  - word store → WRITE.
  - byte/half store → READ.
- READ: mem_rdata_i is sampled at the end of the cycle.
  - Load: extract the lane selected by addr[1:0], extend, then → RESP.
  - Store: merge the new lane into the sampled word, then → WRITE.
- WRITE: mem_we_o=1 for exactly one cycle with mem_wdata_o = merged word (or req word), then → RESP.
- RESP: resp_valid_o=1 for one cycle, then → IDLE. Responses are not back-pressured.
- req_ready_o=0 in every state except IDLE.
- mem_addr_o is held at the latched word address from acceptance until the next acceptance.

## Timing
- Reset values: state IDLE, req_ready_o=1, resp_valid_o=0, resp_rdata_o=0, resp_err_o=00, mem_addr_o=0, mem_wdata_o=0, mem_we_o=0.
- Latency is counted from the acceptance edge to the edge where resp_valid_o is sampled high:
  - error: 1 cycle.
  - load or word store: 2 cycles.
  - byte/half store: 3 cycles.
- Throughput: a new request can be accepted in the cycle after RESP.
- Reset asserted mid-operation (any state): outputs take their reset values immediately, including mem_we_o dropping combinationally with rst_n. The in-flight request is discarded and no response is issued.
- resp_rdata_o and resp_err_o are valid only while resp_valid_o=1. They return to 0 in IDLE.
- Byte lane n = data[8n+7:8n]; half lane = addr[1] selects upper or lower 16 bits.

## Structure
- Package mem_access_pkg holds:
  - size encodings SIZE_B, SIZE_H, SIZE_W.
  - error codes ERR_NONE, ERR_ALIGN, ERR_ROM.
  - the state encoding.
  - the default ROM_LIMIT.
- Sub-module lane_align is combinational and does two jobs:
  - load extraction with sign/zero extension.
  - store merge (old word, new data, addr[1:0], size → merged word).
- The FSM and registers stay in mem_access_unit.

## Test plan
- Reset: hold rst_n=0 → all outputs at reset values, req_ready_o=1. Release → no resp_valid_o without a request.
- LW at 0x1000_0004, mem returns 0xDEAD_BEEF → resp_rdata_o=0xDEAD_BEEF, err 00, resp 2 cycles after accept, mem_we_o never high.
- LB at 0x1000_0003, mem word 0x80FF_1234 → 0xFFFF_FF80. The same access as LBU → 0x0000_0080. LH at 0x1000_0002 → 0xFFFF_80FF.
- SH at 0x1000_0002, wdata 0x0000_ABCD, old word 0x1122_3344:
  - mem_we_o high one cycle with mem_wdata_o=0xABCD_3344, mem_addr_o=0x1000_0000.
  - resp 3 cycles after accept.
- Error paths, each giving resp after 1 cycle with mem_we_o never asserted:
  - SW to 0x0000_0010 → err 10.
  - LH at 0x1000_0001 → err 01.
  - size 11 → err 01.
- rst_n pulled low during WRITE of an SB → mem_we_o drops immediately, no resp_valid_o. After release, req_ready_o=1 and the next LW completes normally.
